edf_irq_ctrl: RTL

Core-side interrupt controller that sits directly downstream of the EDF arbiter. It takes the arbiter's current winner (id and absolute deadline) and offers it to the hart only when it preempts the handler in service, that is, when its deadline is strictly earlier. On acceptance it pulses a claim back to the arbiter. It also keeps a bounded stack of in-service deadlines so that nested handlers resume with the correct preemption threshold on return.

---
 rtl/edf_irq_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/edf_irq_ctrl.sv
// -----------------------------------------------------------------------------
// edf_irq_ctrl
//
// Core-side interrupt controller that sits directly downstream of the EDF
// arbiter. The arbiter's current winner is offered to the hart only when
// its absolute deadline is strictly earlier than the deadline of the handler
// already in service. When the hart accepts, a one-cycle claim pulse goes
// back to the arbiter. A bounded stack of in-service deadlines lets nested
// handlers resume with the correct preemption threshold after mret.
//
// Optional feature macro: EDF_IRQ_CTRL_NEST_EN
//   defined   : nesting up to NestDepth handlers, deadline-gated preemption
//   undefined : no stack, effective depth 1, offers gated only by level==0
//
// Parameters:
//   IdWidth   - width of the interrupt id
//   TsWidth   - deadline/timestamp width
//   NestDepth - maximum number of nested in-service handlers (>=1)
//
// Ports:
//   clk_i         in   clock
//   rst_i         in   asynchronous, active-high reset
//   arb_valid_i   in   arbiter has a pending winner
//   arb_id_i      in   arbiter winner id
//   arb_dl_i      in   winner absolute deadline
//   arb_ready_o   out  one-cycle claim pulse to the arbiter/gateways
//   core_irq_o    out  interrupt offered to the hart
//   core_irq_id_o out  id of the offered interrupt
//   core_ack_i    in   hart takes the offered interrupt (pulse)
//   core_mret_i   in   hart completes the current handler (pulse)
//   cur_dl_o      out  deadline in service, all-ones when idle
//   nest_level_o  out  number of handlers in service
//   err_o         out  sticky protocol error, cleared only by reset
// -----------------------------------------------------------------------------
module edf_irq_ctrl #(
    parameter int IdWidth   = 2,
    parameter int TsWidth   = 64,
    parameter int NestDepth = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           arb_valid_i,
    input  logic [IdWidth-1:0]             arb_id_i,
    input  logic [TsWidth-1:0]             arb_dl_i,
    output logic                           arb_ready_o,
    output logic                           core_irq_o,
    output logic [IdWidth-1:0]             core_irq_id_o,
    input  logic                           core_ack_i,
    input  logic                           core_mret_i,
    output logic [TsWidth-1:0]             cur_dl_o,
    output logic [$clog2(NestDepth+1)-1:0] nest_level_o,
    output logic                           err_o
);

    localparam int LvlW = $clog2(NestDepth + 1);

`ifdef EDF_IRQ_CTRL_NEST_EN
    localparam int EffDepth = NestDepth;
`else
    localparam int EffDepth = 1;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        CLAIM = 2'd2
    } state_t;

    state_t              state;
    logic [IdWidth-1:0]  offer_id;
    logic [TsWidth-1:0]  offer_dl;
    logic [TsWidth-1:0]  cur_dl;
    logic [LvlW-1:0]     level;
    logic                err;

    logic                eligible;
    logic                push;
    logic                pop;
    logic                proto_err;
    logic [TsWidth-1:0]  pop_dl;

    // An arbiter winner may be offered only while there is room for one more
    // nested handler. With nesting enabled it must also strictly beat the
    // threshold in service; an equal deadline never preempts.
`ifdef EDF_IRQ_CTRL_NEST_EN
    assign eligible = arb_valid_i && (level < LvlW'(EffDepth)) && (arb_dl_i < cur_dl);
`else
    assign eligible = arb_valid_i && (level == '0);
`endif

    // A simultaneous mret wins over an ack, so an ack only pushes when alone.
    assign push      = (state == OFFER) && core_ack_i && !core_mret_i;
    assign pop       = core_mret_i && (level != '0);
    assign proto_err = (core_mret_i && (level == '0)) ||
                       (core_ack_i && ((state != OFFER) || core_mret_i));

`ifdef EDF_IRQ_CTRL_NEST_EN
    logic [TsWidth-1:0] stack_q [NestDepth];

    // Saved thresholds of interrupted handlers; entry i holds the threshold
    // that was in force while level was i, so a pop reads entry level-1.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NestDepth; i++) begin
                stack_q[i] <= '1;
            end
        end else begin
            for (int i = 0; i < NestDepth; i++) begin
                if (push && (level == LvlW'(i))) begin
                    stack_q[i] <= cur_dl;
                end
            end
        end
    end

    // Select the entry that becomes the threshold on return from a handler.
    always_comb begin
        pop_dl = '1;
        for (int i = 0; i < NestDepth; i++) begin
            if (level == LvlW'(i + 1)) begin
                pop_dl = stack_q[i];
            end
        end
    end
`else
    // Single-level build: returning from the only handler means idle.
    assign pop_dl = '1;
`endif

    // Offer/claim FSM plus the in-service threshold, level and sticky error.
    // mret is honoured in every state and uses the pre-update threshold for
    // this cycle's eligibility; the popped value takes effect next cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            offer_id <= '0;
            offer_dl <= '1;
            cur_dl   <= '1;
            level    <= '0;
            err      <= 1'b0;
        end else begin
            if (proto_err) begin
                err <= 1'b1;
            end
            if (pop) begin
                cur_dl <= pop_dl;
                level  <= level - LvlW'(1);
            end

            unique case (state)
                IDLE: begin
                    if (eligible) begin
                        offer_id <= arb_id_i;
                        offer_dl <= arb_dl_i;
                        state    <= OFFER;
                    end
                end
                OFFER: begin
                    if (push) begin
                        cur_dl <= offer_dl;
                        level  <= level + LvlW'(1);
                        state  <= CLAIM;
                    end else if (core_ack_i || !eligible) begin
                        state <= IDLE;
                    end else if (arb_id_i != offer_id) begin
                        offer_id <= arb_id_i;
                        offer_dl <= arb_dl_i;
                    end
                end
                CLAIM: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign core_irq_o    = (state == OFFER);
    assign arb_ready_o   = (state == CLAIM);
    assign core_irq_id_o = offer_id;
    assign cur_dl_o      = cur_dl;
    assign nest_level_o  = level;
    assign err_o         = err;

endmodule
